tcdm_reservation_table: RTL and testbench



---
 rtl/tcdm_resv_pkg.sv | 8 +
 rtl/tcdm_resv_slot_finder.sv | 36 +++
 rtl/tcdm_reservation_table.sv | 168 ++++++++++++++++
 tb/tb_tcdm_reservation_table.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tcdm_resv_pkg.sv
// Shared AMO encodings for the TCDM LR/SC reservation table.
package tcdm_resv_pkg;

  localparam logic [3:0] AmoNone = 4'h0;
  localparam logic [3:0] AmoLR   = 4'hA;
  localparam logic [3:0] AmoSC   = 4'hB;

endpackage

// File: rtl/tcdm_resv_slot_finder.sv
// Combinational lookup over the reservation slots: owner slot, free slot and
// the mask of valid slots holding the requested word.
module tcdm_resv_slot_finder #(
  parameter int unsigned NumSlots = 4,
  parameter int unsigned IdxW     = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
  input  logic [NumSlots-1:0] valid,
  input  logic [NumSlots-1:0] id_match,
  input  logic [NumSlots-1:0] addr_match,
  output logic [IdxW-1:0]     owner_idx,
  output logic                owner_hit,
  output logic [NumSlots-1:0] addr_mask,
  output logic [IdxW-1:0]     free_idx,
  output logic                free_hit
);

  always_comb begin
    owner_idx = '0;
    owner_hit = 1'b0;
    free_idx  = '0;
    free_hit  = 1'b0;
    addr_mask = valid & addr_match;
    // Walk downwards so the lowest matching index is the one that sticks.
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (valid[i] && id_match[i]) begin
        owner_idx = IdxW'(i);
        owner_hit = 1'b1;
      end
      if (!valid[i]) begin
        free_idx = IdxW'(i);
        free_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcdm_reservation_table.sv
// Per-bank multi-slot LR/SC reservation monitor in a one-deep elastic slice.
// Optional SC statistics counters are built when TCDM_RESV_STATS_EN is defined.
module tcdm_reservation_table
  import tcdm_resv_pkg::*;
#(
  parameter int unsigned NumSlots    = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned MetaWidth   = 16,
  parameter int unsigned CoreIdWidth = 8,
  parameter int unsigned BeWidth     = DataWidth / 8,
  parameter int unsigned OccWidth    = $clog2(NumSlots + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AddrWidth-1:0]   in_addr_i,
  input  logic [3:0]             in_amo_i,
  input  logic                   in_write_i,
  input  logic [DataWidth-1:0]   in_wdata_i,
  input  logic [BeWidth-1:0]     in_be_i,
  input  logic [CoreIdWidth-1:0] in_core_id_i,
  input  logic [MetaWidth-1:0]   in_meta_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [AddrWidth-1:0]   out_addr_o,
  output logic [3:0]             out_amo_o,
  output logic                   out_write_o,
  output logic [DataWidth-1:0]   out_wdata_o,
  output logic [BeWidth-1:0]     out_be_o,
  output logic [MetaWidth-1:0]   out_meta_o,
  output logic                   out_sc_fail_o,
  output logic [OccWidth-1:0]    occupancy_o,
  output logic [31:0]            sc_success_cnt_o,
  output logic [31:0]            sc_fail_cnt_o
);

  localparam int unsigned OffW  = (BeWidth > 1) ? $clog2(BeWidth) : 0;
  localparam int unsigned WordW = AddrWidth - OffW;
  localparam int unsigned IdxW  = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  typedef struct packed {
    logic                   valid;
    logic [CoreIdWidth-1:0] core_id;
    logic [WordW-1:0]       word_addr;
  } slot_t;

  slot_t            slots_q [NumSlots];
  slot_t            slots_d [NumSlots];
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [OccWidth-1:0] occ_d;

  logic [NumSlots-1:0] valid_vec, id_match, addr_match, addr_mask, both_match;
  logic [IdxW-1:0]     owner_idx, free_idx;
  logic                owner_hit, free_hit;
  logic [WordW-1:0]    in_word;
  logic                accept, is_lr, is_sc, sc_ok;

  assign in_word    = in_addr_i[AddrWidth-1:OffW];
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign is_lr      = (in_amo_i == AmoLR) && !in_write_i;
  assign is_sc      = (in_amo_i == AmoSC) && in_write_i;
  assign sc_ok      = is_sc && (|both_match);

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      valid_vec[i]  = slots_q[i].valid;
      id_match[i]   = slots_q[i].core_id == in_core_id_i;
      addr_match[i] = slots_q[i].word_addr == in_word;
    end
    both_match = valid_vec & id_match & addr_match;
  end

  tcdm_resv_slot_finder #(
    .NumSlots (NumSlots),
    .IdxW     (IdxW)
  ) u_finder (
    .valid      (valid_vec),
    .id_match   (id_match),
    .addr_match (addr_match),
    .owner_idx  (owner_idx),
    .owner_hit  (owner_hit),
    .addr_mask  (addr_mask),
    .free_idx   (free_idx),
    .free_hit   (free_hit)
  );

  // All decisions read the pre-update table; slots_d is the post-accept image.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) slots_d[i] = slots_q[i];
    ptr_d = ptr_q;
    if (accept) begin
      if (is_lr) begin
        if (owner_hit) begin
          slots_d[owner_idx].word_addr = in_word;
        end else if (free_hit) begin
          slots_d[free_idx] = '{valid: 1'b1, core_id: in_core_id_i, word_addr: in_word};
        end else begin
          slots_d[ptr_q] = '{valid: 1'b1, core_id: in_core_id_i, word_addr: in_word};
          ptr_d = (ptr_q == IdxW'(NumSlots - 1)) ? '0 : ptr_q + 1'b1;
        end
      end else if (is_sc) begin
        if (sc_ok) begin
          for (int i = 0; i < NumSlots; i++) if (addr_mask[i]) slots_d[i].valid = 1'b0;
        end else if (owner_hit) begin
          slots_d[owner_idx].valid = 1'b0;
        end
      end else if (in_write_i || (in_amo_i != AmoNone)) begin
        for (int i = 0; i < NumSlots; i++) if (addr_mask[i]) slots_d[i].valid = 1'b0;
      end
    end
    occ_d = '0;
    for (int i = 0; i < NumSlots; i++) occ_d = occ_d + OccWidth'(slots_d[i].valid);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) slots_q[i] <= '0;
      ptr_q         <= '0;
      occupancy_o   <= '0;
      out_valid_o   <= 1'b0;
      out_addr_o    <= '0;
      out_amo_o     <= '0;
      out_write_o   <= 1'b0;
      out_wdata_o   <= '0;
      out_be_o      <= '0;
      out_meta_o    <= '0;
      out_sc_fail_o <= 1'b0;
    end else begin
      for (int i = 0; i < NumSlots; i++) slots_q[i] <= slots_d[i];
      ptr_q       <= ptr_d;
      occupancy_o <= occ_d;
      if (in_ready_o) out_valid_o <= in_valid_i;
      if (accept) begin
        out_addr_o    <= in_addr_i;
        out_amo_o     <= in_amo_i;
        out_write_o   <= in_write_i && !(is_sc && !sc_ok);
        out_wdata_o   <= in_wdata_i;
        out_be_o      <= (is_sc && !sc_ok) ? '0 : in_be_i;
        out_meta_o    <= in_meta_i;
        out_sc_fail_o <= is_sc && !sc_ok;
      end
    end
  end

`ifdef TCDM_RESV_STATS_EN
  logic [31:0] succ_q, fail_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      succ_q <= '0;
      fail_q <= '0;
    end else if (accept && is_sc) begin
      if (sc_ok && (succ_q != '1)) succ_q <= succ_q + 32'd1;
      if (!sc_ok && (fail_q != '1)) fail_q <= fail_q + 32'd1;
    end
  end

  assign sc_success_cnt_o = succ_q;
  assign sc_fail_cnt_o    = fail_q;
`else
  assign sc_success_cnt_o = '0;
  assign sc_fail_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_tcdm_reservation_table.sv
// Directed bench for tcdm_reservation_table (default 4 slots); expected
// statistics follow TCDM_RESV_STATS_EN.
module tb_tcdm_reservation_table;
  import tcdm_resv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_addr_i = '0;
  logic [3:0]  in_amo_i = '0;
  logic        in_write_i = 1'b0;
  logic [31:0] in_wdata_i = '0;
  logic [3:0]  in_be_i = 4'hF;
  logic [7:0]  in_core_id_i = '0;
  logic [15:0] in_meta_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_addr_o;
  logic [3:0]  out_amo_o;
  logic        out_write_o;
  logic [31:0] out_wdata_o;
  logic [3:0]  out_be_o;
  logic [15:0] out_meta_o;
  logic        out_sc_fail_o;
  logic [2:0]  occupancy_o;
  logic [31:0] sc_success_cnt_o;
  logic [31:0] sc_fail_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  tcdm_reservation_table dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_addr_i        (in_addr_i),
    .in_amo_i         (in_amo_i),
    .in_write_i       (in_write_i),
    .in_wdata_i       (in_wdata_i),
    .in_be_i          (in_be_i),
    .in_core_id_i     (in_core_id_i),
    .in_meta_i        (in_meta_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_addr_o       (out_addr_o),
    .out_amo_o        (out_amo_o),
    .out_write_o      (out_write_o),
    .out_wdata_o      (out_wdata_o),
    .out_be_o         (out_be_o),
    .out_meta_o       (out_meta_o),
    .out_sc_fail_o    (out_sc_fail_o),
    .occupancy_o      (occupancy_o),
    .sc_success_cnt_o (sc_success_cnt_o),
    .sc_fail_cnt_o    (sc_fail_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] amo, input logic wr, input logic [31:0] addr,
                       input logic [7:0] core, input logic [31:0] wdata);
    in_valid_i   = 1'b1;
    in_amo_i     = amo;
    in_write_i   = wr;
    in_addr_i    = addr;
    in_core_id_i = core;
    in_wdata_i   = wdata;
    in_be_i      = 4'hF;
    in_meta_i    = addr[15:0] ^ 16'h5A00;
  endtask

  // Drive at negedge, accept at posedge, check the registered result at the next negedge.
  task automatic send(input string tag, input logic [3:0] amo, input logic wr,
                      input logic [31:0] addr, input logic [7:0] core, input logic [31:0] wdata,
                      input logic exp_wr, input logic exp_fail, input logic [2:0] exp_occ);
    drive(amo, wr, addr, core, wdata);
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, ".valid"}, {31'd0, out_valid_o}, 32'd1);
    check({tag, ".addr"},  out_addr_o, addr);
    check({tag, ".write"}, {31'd0, out_write_o}, {31'd0, exp_wr});
    check({tag, ".fail"},  {31'd0, out_sc_fail_o}, {31'd0, exp_fail});
    check({tag, ".be"},    {28'd0, out_be_o}, exp_fail ? 32'd0 : 32'hF);
    check({tag, ".occ"},   {29'd0, occupancy_o}, {29'd0, exp_occ});
  endtask

  initial begin
    #12;
    check("rst.valid", {31'd0, out_valid_o}, 32'd0);
    check("rst.ready", {31'd0, in_ready_o}, 32'd1);
    check("rst.occ",   {29'd0, occupancy_o}, 32'd0);
    check("rst.succ",  sc_success_cnt_o, 32'd0);
    check("rst.failc", sc_fail_cnt_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic LR/SC pair
    send("lr3",   AmoLR, 1'b0, 32'h100, 8'd3, 32'h0,    1'b0, 1'b0, 3'd1);
    send("sc3",   AmoSC, 1'b1, 32'h100, 8'd3, 32'hDEAD, 1'b1, 1'b0, 3'd0);
    check("sc3.wdata", out_wdata_o, 32'hDEAD);
    check("sc3.meta",  {16'd0, out_meta_o}, 32'h5B00);

    // Plain write to the same word from another core kills the reservation
    send("lr3b",  AmoLR, 1'b0, 32'h100, 8'd3, 32'h0,  1'b0, 1'b0, 3'd1);
    send("wr5",   AmoNone, 1'b1, 32'h102, 8'd5, 32'h7, 1'b1, 1'b0, 3'd0);
    send("sc3b",  AmoSC, 1'b1, 32'h100, 8'd3, 32'h9,  1'b0, 1'b1, 3'd0);

    // Fill four slots, fifth LR evicts slot 0 (core 0), pointer moves to 1
    send("lr0",   AmoLR, 1'b0, 32'h10, 8'd0, 32'h0, 1'b0, 1'b0, 3'd1);
    send("lr1",   AmoLR, 1'b0, 32'h20, 8'd1, 32'h0, 1'b0, 1'b0, 3'd2);
    send("lr2",   AmoLR, 1'b0, 32'h30, 8'd2, 32'h0, 1'b0, 1'b0, 3'd3);
    send("lr3c",  AmoLR, 1'b0, 32'h40, 8'd3, 32'h0, 1'b0, 1'b0, 3'd4);
    send("lr4",   AmoLR, 1'b0, 32'h50, 8'd4, 32'h0, 1'b0, 1'b0, 3'd4);
    send("sc0",   AmoSC, 1'b1, 32'h10, 8'd0, 32'h1, 1'b0, 1'b1, 3'd4);
    send("sc4",   AmoSC, 1'b1, 32'h50, 8'd4, 32'h2, 1'b1, 1'b0, 3'd3);
    // Slot 0 is free again; next full-table LR evicts slot 1 (core 1)
    send("lr5",   AmoLR, 1'b0, 32'h60, 8'd5, 32'h0, 1'b0, 1'b0, 3'd4);
    send("lr6",   AmoLR, 1'b0, 32'h70, 8'd6, 32'h0, 1'b0, 1'b0, 3'd4);
    send("sc1",   AmoSC, 1'b1, 32'h20, 8'd1, 32'h3, 1'b0, 1'b1, 3'd4);
    send("sc2",   AmoSC, 1'b1, 32'h30, 8'd2, 32'h4, 1'b1, 1'b0, 3'd3);
    send("clr40", 4'h2,  1'b1, 32'h40, 8'd9, 32'h0, 1'b1, 1'b0, 3'd2);
    send("clr60", AmoNone, 1'b1, 32'h60, 8'd9, 32'h0, 1'b1, 1'b0, 3'd1);
    send("clr70", AmoNone, 1'b1, 32'h70, 8'd9, 32'h0, 1'b1, 1'b0, 3'd0);

    // Two cores reserve the same word; winner's SC clears both
    send("lr1s",  AmoLR, 1'b0, 32'h200, 8'd1, 32'h0, 1'b0, 1'b0, 3'd1);
    send("lr2s",  AmoLR, 1'b0, 32'h200, 8'd2, 32'h0, 1'b0, 1'b0, 3'd2);
    send("sc2s",  AmoSC, 1'b1, 32'h200, 8'd2, 32'h5, 1'b1, 1'b0, 3'd0);
    send("sc1s",  AmoSC, 1'b1, 32'h200, 8'd1, 32'h6, 1'b0, 1'b1, 3'd0);
    send("rd",    AmoNone, 1'b0, 32'h200, 8'd1, 32'h0, 1'b0, 1'b0, 3'd0);

    // Backpressure: output must hold, input must stall
    send("lr7",   AmoLR, 1'b0, 32'h300, 8'd7, 32'h0, 1'b0, 1'b0, 3'd1);
    out_ready_i = 1'b0;
    drive(AmoNone, 1'b0, 32'h304, 8'd7, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("bp.ready", {31'd0, in_ready_o}, 32'd0);
      check("bp.valid", {31'd0, out_valid_o}, 32'd1);
      check("bp.addr",  out_addr_o, 32'h300);
    end
    out_ready_i = 1'b1;
    send("rd304", AmoNone, 1'b0, 32'h304, 8'd7, 32'h0, 1'b0, 1'b0, 3'd1);
    send("rd308", AmoNone, 1'b0, 32'h308, 8'd7, 32'h0, 1'b0, 1'b0, 3'd1);
    in_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("drain.valid", {31'd0, out_valid_o}, 32'd0);

`ifdef TCDM_RESV_STATS_EN
    check("stat.succ", sc_success_cnt_o, 32'd4);
    check("stat.fail", sc_fail_cnt_o, 32'd4);
`else
    check("stat.succ", sc_success_cnt_o, 32'd0);
    check("stat.fail", sc_fail_cnt_o, 32'd0);
`endif

    // Reset while a request is in flight
    send("lr7r",  AmoLR, 1'b0, 32'h300, 8'd7, 32'h0, 1'b0, 1'b0, 3'd1);
    drive(AmoLR, 1'b0, 32'h400, 8'd9, 32'h0);
    #2 rst_ni = 1'b0;
    #1;
    check("mrst.valid", {31'd0, out_valid_o}, 32'd0);
    check("mrst.occ",   {29'd0, occupancy_o}, 32'd0);
    check("mrst.succ",  sc_success_cnt_o, 32'd0);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    send("sc7r",  AmoSC, 1'b1, 32'h300, 8'd7, 32'h8, 1'b0, 1'b1, 3'd0);
`ifdef TCDM_RESV_STATS_EN
    check("stat2.fail", sc_fail_cnt_o, 32'd1);
`else
    check("stat2.fail", sc_fail_cnt_o, 32'd0);
`endif
    in_valid_i = 1'b0;
    @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
